// File: rtl/pipe_stage_latch_pkg.sv
// Shared lc3b pipeline types: control-word layout, bubble control word and
// the slot flag packing used by the pipeline-stage latch.
package pipe_stage_latch_pkg;

  localparam int unsigned CONTROL_WIDTH = 12;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_NOT  = 3'd3,
    ALU_SHF  = 3'd4
  } alu_op_t;

  typedef struct packed {
    alu_op_t    aluop;
    logic       regfile_we;
    logic       mem_read;
    logic       mem_write;
    logic       br_en;
    logic [1:0] pcmux;
    logic [1:0] destmux;
    logic       cc_we;
  } lc3b_cw_t;

  localparam lc3b_cw_t LC3B_NOP_CW_S = '{
    aluop:      ALU_ADD,
    regfile_we: 1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    br_en:      1'b0,
    pcmux:      2'b00,
    destmux:    2'b00,
    cc_we:      1'b0
  };

  localparam logic [CONTROL_WIDTH-1:0] LC3B_NOP_CW = LC3B_NOP_CW_S;

  typedef struct packed {
    logic valid;
    logic bubble;
  } slot_flags_t;

  // Operand bus stays 1 bit wide when no operands are carried.
  function automatic int unsigned src_width(input int unsigned num_src,
                                            input int unsigned word_w);
    return (num_src == 0) ? 1 : num_src * word_w;
  endfunction

endpackage

// File: rtl/pipe_stage_latch_slot.sv
// One storage slot of the pipeline latch: valid/bubble flags plus payload,
// with reset > clear > load priority and squash-on-load.
module pipe_slot
  import pipe_stage_latch_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned SRC_W  = 32,
  parameter int unsigned CW_W   = CONTROL_WIDTH,
  parameter logic [CW_W-1:0] NOP_CW = LC3B_NOP_CW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic              squash,
  input  logic [WORD_W-1:0] ir_d,
  input  logic [WORD_W-1:0] pc_d,
  input  logic [SRC_W-1:0]  src_d,
  input  logic [CW_W-1:0]   cw_d,
  output logic              valid,
  output logic              bubble,
  output logic [WORD_W-1:0] ir_q,
  output logic [WORD_W-1:0] pc_q,
  output logic [SRC_W-1:0]  src_q,
  output logic [CW_W-1:0]   cw_q
);

  slot_flags_t flags;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags <= '0;
      ir_q  <= '0;
      pc_q  <= '0;
      src_q <= '0;
      cw_q  <= NOP_CW;
    end else if (clear) begin
      flags.valid <= 1'b0;
    end else if (load) begin
      flags.valid  <= 1'b1;
      flags.bubble <= squash;
      ir_q         <= squash ? '0 : ir_d;
      pc_q         <= pc_d;
      src_q        <= squash ? '0 : src_d;
      cw_q         <= squash ? NOP_CW : cw_d;
    end
  end

  assign valid  = flags.valid;
  assign bubble = flags.bubble;

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline-stage latch: head + skid slot with valid/ready handshake,
// squash-to-bubble and flush. Empty head drives bubble-safe constants.
module pipe_stage_latch
  import pipe_stage_latch_pkg::*;
#(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CW_W    = CONTROL_WIDTH,
  parameter logic [CW_W-1:0] NOP_CW = LC3B_NOP_CW
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     squash_in,
  input  logic                                     flush,
  input  logic [WORD_W-1:0]                        IR_in,
  input  logic [WORD_W-1:0]                        PC_in,
  input  logic [src_width(NUM_SRC, WORD_W)-1:0]    SRC_in,
  input  logic [CW_W-1:0]                          CW_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [WORD_W-1:0]                        IR_out,
  output logic [WORD_W-1:0]                        PC_out,
  output logic [src_width(NUM_SRC, WORD_W)-1:0]    SRC_out,
  output logic [CW_W-1:0]                          CW_out,
  output logic                                     out_bubble,
  output logic [1:0]                               occupancy
);

  localparam int unsigned SRC_W = src_width(NUM_SRC, WORD_W);

  logic              head_v, head_b, skid_v, skid_b;
  logic [WORD_W-1:0] head_ir, head_pc, skid_ir, skid_pc;
  logic [SRC_W-1:0]  head_src, skid_src, src_d;
  logic [CW_W-1:0]   head_cw, skid_cw;

  logic              xfer_in, xfer_out;
  logic              head_load, head_clear, head_from_skid, head_squash;
  logic              skid_load, skid_clear;
  logic [WORD_W-1:0] head_ir_d, head_pc_d;
  logic [SRC_W-1:0]  head_src_d;
  logic [CW_W-1:0]   head_cw_d;

  assign src_d    = (NUM_SRC > 0) ? SRC_in : '0;
  assign in_ready = !skid_v && !flush;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = head_v && out_ready;

  always_comb begin
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!head_v) begin
      head_load = xfer_in;
    end else if (xfer_out) begin
      if (skid_v) begin
        head_load      = 1'b1;
        head_from_skid = 1'b1;
        skid_clear     = 1'b1;
      end else if (xfer_in) begin
        head_load = 1'b1;
      end else begin
        head_clear = 1'b1;
      end
    end else begin
      skid_load = xfer_in;
    end
  end

  // Re-applying squash on a skid bubble is idempotent and preserves its PC.
  assign head_squash = head_from_skid ? skid_b : squash_in;
  assign head_ir_d   = head_from_skid ? skid_ir  : IR_in;
  assign head_pc_d   = head_from_skid ? skid_pc  : PC_in;
  assign head_src_d  = head_from_skid ? skid_src : src_d;
  assign head_cw_d   = head_from_skid ? skid_cw  : CW_in;

  pipe_slot #(
    .WORD_W(WORD_W), .SRC_W(SRC_W), .CW_W(CW_W), .NOP_CW(NOP_CW)
  ) u_head (
    .clk(clk), .reset_n(reset_n), .load(head_load), .clear(head_clear),
    .squash(head_squash), .ir_d(head_ir_d), .pc_d(head_pc_d),
    .src_d(head_src_d), .cw_d(head_cw_d), .valid(head_v), .bubble(head_b),
    .ir_q(head_ir), .pc_q(head_pc), .src_q(head_src), .cw_q(head_cw)
  );

  pipe_slot #(
    .WORD_W(WORD_W), .SRC_W(SRC_W), .CW_W(CW_W), .NOP_CW(NOP_CW)
  ) u_skid (
    .clk(clk), .reset_n(reset_n), .load(skid_load), .clear(skid_clear),
    .squash(squash_in), .ir_d(IR_in), .pc_d(PC_in), .src_d(src_d),
    .cw_d(CW_in), .valid(skid_v), .bubble(skid_b), .ir_q(skid_ir),
    .pc_q(skid_pc), .src_q(skid_src), .cw_q(skid_cw)
  );

  assign out_valid  = head_v;
  assign out_bubble = head_v && head_b;
  assign IR_out     = head_v ? head_ir  : '0;
  assign PC_out     = head_v ? head_pc  : '0;
  assign SRC_out    = head_v ? head_src : '0;
  assign CW_out     = head_v ? head_cw  : NOP_CW;
  assign occupancy  = {1'b0, head_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Bench for pipe_stage_latch: directed scenarios then random traffic, all
// checked against a FIFO-queue reference model of the stage latch.
module tb_pipe_stage_latch;
  import pipe_stage_latch_pkg::*;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SRC_W  = 32;
  localparam int unsigned CW_W   = CONTROL_WIDTH;

  logic              clk = 1'b0;
  logic              reset_n, in_valid, in_ready, squash_in, flush;
  logic [WORD_W-1:0] IR_in, PC_in, IR_out, PC_out;
  logic [SRC_W-1:0]  SRC_in, SRC_out;
  logic [CW_W-1:0]   CW_in, CW_out;
  logic              out_valid, out_ready, out_bubble;
  logic [1:0]        occupancy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] pc;
    logic [SRC_W-1:0]  src;
    logic [CW_W-1:0]   cw;
    logic              bubble;
  } ent_t;

  ent_t q[$];

  pipe_stage_latch #(
    .WORD_W(WORD_W), .NUM_SRC(2), .CW_W(CW_W), .NOP_CW(LC3B_NOP_CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .squash_in(squash_in), .flush(flush), .IR_in(IR_in), .PC_in(PC_in),
    .SRC_in(SRC_in), .CW_in(CW_in), .out_valid(out_valid),
    .out_ready(out_ready), .IR_out(IR_out), .PC_out(PC_out),
    .SRC_out(SRC_out), .CW_out(CW_out), .out_bubble(out_bubble),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, then advance one clock and update it.
  task automatic cycle(input bit check);
    ent_t e, ne;
    bit   m_ready, acc, pop;
    #1;
    m_ready = (q.size() < 2) && !flush;
    if (check) begin
      if (q.size() > 0) e = q[0];
      else e = '{ir: '0, pc: '0, src: '0, cw: LC3B_NOP_CW, bubble: 1'b0};
      chk("in_ready",   64'(in_ready),   64'(m_ready));
      chk("out_valid",  64'(out_valid),  64'(q.size() > 0));
      chk("occupancy",  64'(occupancy),  64'(q.size()));
      chk("IR_out",     64'(IR_out),     64'(e.ir));
      chk("PC_out",     64'(PC_out),     64'(e.pc));
      chk("SRC_out",    64'(SRC_out),    64'(e.src));
      chk("CW_out",     64'(CW_out),     64'(e.cw));
      chk("out_bubble", 64'(out_bubble), 64'(e.bubble));
    end
    pop = (q.size() > 0) && out_ready;
    acc = in_valid && m_ready;
    if (squash_in) ne = '{ir: '0, pc: PC_in, src: '0, cw: LC3B_NOP_CW, bubble: 1'b1};
    else           ne = '{ir: IR_in, pc: PC_in, src: SRC_in, cw: CW_in, bubble: 1'b0};
    @(posedge clk);
    if (!reset_n || flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ne);
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [WORD_W-1:0] ir,
                       input logic [WORD_W-1:0] pc);
    in_valid = v;
    IR_in    = ir;
    PC_in    = pc;
    SRC_in   = {ir, ~ir};
    CW_in    = CW_W'(ir ^ 16'h0A5A);
  endtask

  initial begin
    reset_n = 1'b0; squash_in = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'h0BAD, 16'h0100);
    @(negedge clk);

    // Reset held two cycles with in_valid asserted.
    cycle(1'b0);
    cycle(1'b1);
    reset_n = 1'b1;
    drive(1'b0, '0, '0);
    cycle(1'b1);

    // Streaming with out_ready=1.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 16'h0200 + 16'(2 * i));
      cycle(1'b1);
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    drive(1'b0, '0, '0);
    cycle(1'b1);

    // Backpressure: third entry waits upstream until space frees.
    out_ready = 1'b0;
    drive(1'b1, 16'h2001, 16'h0300); cycle(1'b1);
    drive(1'b1, 16'h2002, 16'h0302); cycle(1'b1);
    drive(1'b1, 16'h2003, 16'h0304); cycle(1'b1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_ir",  64'(IR_out),   64'h2001);
    out_ready = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    drive(1'b0, '0, '0);
    cycle(1'b1);
    cycle(1'b1);

    // Squash.
    out_ready = 1'b0;
    squash_in = 1'b1;
    drive(1'b1, 16'h3ABC, 16'h0040);
    cycle(1'b1);
    squash_in = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("sq_pc",     64'(PC_out),     64'h0040);
    chk("sq_bubble", 64'(out_bubble), 64'd1);
    cycle(1'b1);
    out_ready = 1'b1;
    cycle(1'b1);

    // Flush while full, with an entry offered on the flush cycle.
    out_ready = 1'b0;
    drive(1'b1, 16'h4001, 16'h0400); cycle(1'b1);
    drive(1'b1, 16'h4002, 16'h0402); cycle(1'b1);
    flush = 1'b1;
    drive(1'b1, 16'h4003, 16'h0404); cycle(1'b1);
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    cycle(1'b1);
    cycle(1'b1);

    // Reset mid-operation.
    out_ready = 1'b0;
    drive(1'b1, 16'h5001, 16'h0500); cycle(1'b1);
    drive(1'b1, 16'h5002, 16'h0502); cycle(1'b1);
    reset_n = 1'b0;
    drive(1'b0, '0, '0);
    cycle(1'b1);
    reset_n = 1'b1;
    out_ready = 1'b1;
    cycle(1'b1);
    cycle(1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
      SRC_in    = $urandom;
      CW_in     = CW_W'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      squash_in = 1'($urandom_range(0, 7) == 0);
      flush     = 1'($urandom_range(0, 19) == 0);
      reset_n   = 1'($urandom_range(0, 49) != 0);
      cycle(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
